// File: rtl/booth_arb_pkg.sv
// -----------------------------------------------------------------------------
// booth_arb_pkg
// Shared types and helpers for the booth multiplier arbiter.
//   arb_state_t : controller states (IDLE, START, WAIT, DONE)
//   DEF_WIDTH   : default operand width
//   DEF_NREQ    : default number of requesters
//   op_slice()  : extracts requester i's operand from a packed operand bus
// -----------------------------------------------------------------------------
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

    // Upper bounds for the generic slice helper; NREQ*WIDTH must fit MAX_BUS_W
    // and WIDTH must fit MAX_WIDTH.
    localparam int MAX_WIDTH = 32;
    localparam int MAX_BUS_W = 512;

    // Returns bits [idx*w +: w] of bus, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] op_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   w
    );
        logic [MAX_WIDTH-1:0] mask;
        mask = (MAX_WIDTH'(1) << w) - MAX_WIDTH'(1);
        return MAX_WIDTH'(bus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request bit at or after the
// pointer, wrapping modulo NREQ.
//   i_req   : request vector
//   i_ptr   : highest-priority index
//   o_grant : one-hot pick, or zero when no request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant
);

    int   w_idx;
    logic w_found;

    // Scan from the pointer upwards; the first hit wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[PTR_W'(w_idx)]) begin
                o_grant[PTR_W'(w_idx)] = 1'b1;
                w_found                = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mul_arbiter
// Shares one booth multiplier among NREQ requesters. A round-robin pick
// selects a requester, its operands are latched onto mul_a/mul_b, mul_start is
// held until the multiplier reports busy, and when busy falls the product is
// captured into result and done pulses for that requester.
//
// Ports:
//   clk, reset          : rising-edge clock, async active-high reset
//   req[NREQ]           : request levels
//   op_a/op_b           : packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant[NREQ]         : one-hot, requester currently served
//   done[NREQ]          : one-hot one-cycle completion pulse
//   result[2*WIDTH]     : last captured product
//   mul_a/mul_b/mul_start, mul_busy/mul_ab : multiplier handshake
//   err[NREQ]           : one-hot one-cycle watchdog abort pulse
//
// Optional build macro BOOTH_ARB_TIMEOUT_EN: adds a watchdog that aborts an
// operation after TIMEOUT_CYCLES cycles in START/WAIT. Without it err is 0 and
// the controller waits on mul_busy indefinitely.
// -----------------------------------------------------------------------------
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int NREQ           = DEF_NREQ,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [2*WIDTH-1:0]    result,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    output logic                  mul_start,
    input  logic                  mul_busy,
    input  logic [2*WIDTH-1:0]    mul_ab,
    output logic [NREQ-1:0]       err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_done;
    logic [2*WIDTH-1:0] r_result;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_mul_start;

    logic [NREQ-1:0]    w_pick;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_abort;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    // Operand mux driven by the one-hot pick (AND-OR, no priority needed).
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_a = w_sel_a | ({WIDTH{w_pick[PTR_W'(i)]}} &
                                 WIDTH'(op_slice(MAX_BUS_W'(op_a), i, WIDTH)));
            w_sel_b = w_sel_b | ({WIDTH{w_pick[PTR_W'(i)]}} &
                                 WIDTH'(op_slice(MAX_BUS_W'(op_b), i, WIDTH)));
        end
    end

    // Pointer that follows the requester currently held in r_grant.
    always_comb begin
        w_next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_next_ptr = w_next_ptr | ({PTR_W{r_grant[PTR_W'(i)]}} & PTR_W'((i + 1) % NREQ));
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd;
    logic [NREQ-1:0] r_err;

    assign w_abort = ((r_state == START) || (r_state == WAIT)) &&
                     (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: zero in IDLE (the only way into START), counts in START/WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd  <= '0;
            r_err <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_wd <= '0;
            end else if ((r_state == START) || (r_state == WAIT)) begin
                r_wd <= r_wd + WD_W'(1);
            end else begin
                r_wd <= r_wd;
            end
            if (w_abort) begin
                r_err <= r_grant;
            end else begin
                r_err <= '0;
            end
        end
    end

    assign err = r_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_abort          = 1'b0;
    assign err              = '0;
`endif

    // Controller FSM: arbitration, start/busy handshake, capture and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant     <= w_pick;
                        r_mul_a     <= w_sel_a;
                        r_mul_b     <= w_sel_b;
                        r_mul_start <= 1'b1;
                        r_state     <= START;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                START: begin
                    if (w_abort) begin
                        r_grant     <= '0;
                        r_mul_start <= 1'b0;
                        r_ptr       <= w_next_ptr;
                        r_state     <= IDLE;
                    end else if (mul_busy) begin
                        r_mul_start <= 1'b0;
                        r_state     <= WAIT;
                    end else begin
                        r_state <= START;
                    end
                end
                WAIT: begin
                    if (w_abort) begin
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else if (!mul_busy) begin
                        // done and the grant release appear together in DONE.
                        r_result <= mul_ab;
                        r_done   <= r_grant;
                        r_grant  <= '0;
                        r_ptr    <= w_next_ptr;
                        r_state  <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign result    = r_result;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_mul_start;

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one booth multiplier among NREQ requesters (ALU, address-gen, test port), sequencing its start/busy handshake.
- Round-robin grant; latches the granted requester's operands and drives the multiplier's a, b and start.
- Waits for busy to fall, captures ab, and returns the product with a one-cycle done pulse to that requester.
- Sits between the requesters and the booth instance in the datapath.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- NREQ, 4, number of requesters, minimum 2.
- TIMEOUT_CYCLES, 64, watchdog limit; used only when the optional feature is enabled.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op_a  in  NREQ*WIDTH  packed operand A; requester i uses slice [i*WIDTH +: WIDTH].
- op_b  in  NREQ*WIDTH  packed operand B, same packing as op_a.
- grant  out  NREQ  one-hot; identifies the requester currently being served.
- done  out  NREQ  one-hot, one-cycle pulse: result is valid for that requester.
- result  out  2*WIDTH  last captured product; held until the next capture.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_start  out  1  start to the multiplier.
- mul_busy  in  1  busy from the multiplier.
- mul_ab  in  2*WIDTH  product from the multiplier.
- err  out  NREQ  one-hot, one-cycle abort pulse; stays 0 unless BOOTH_ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset (async, any state): state = IDLE; rr pointer = 0; grant, done, err, result, mul_a, mul_b, mul_start all = 0.
- Reset mid-operation abandons the operation; no done pulse is issued.
- Operands are two's-complement signed; the multiplier's signed product passes through unmodified.
- IDLE:
  - if any req bit is set, pick the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - Register grant (one-hot); latch that requester's op_a/op_b into mul_a/mul_b; set mul_start = 1; go to START.
- START:
  - hold mul_start = 1 until mul_busy is sampled 1, then clear mul_start and go to WAIT.
  - mul_start is always asserted for at least one cycle.
- WAIT:
  - when mul_busy is sampled 0, go to DONE and capture result <= mul_ab.
- DONE (one cycle):
  - done[g] = 1; grant cleared; rr pointer = g+1 mod NREQ; go to IDLE.
  - A new grant is issued at the earliest in the cycle after DONE.
- mul_a/mul_b stay stable from grant until the next grant; they never change mid-operation.
- Operand sampling: op_a/op_b are sampled only in the grant cycle. Requesters must hold them stable from raising req until done.
- Requester drops req mid-operation: the operation completes and done still pulses (requester ignores it). The rr pointer advances normally.
- Requester's req is still high after done: treated as a new request, but it gets lowest priority on the next arbitration.
- All requesters asserting req continuously: service order is 0,1,…,NREQ-1,0 with no starvation.
- Latency (req to done) = 1 grant cycle + START cycles until busy is seen + multiplier busy time + 1 DONE cycle.
- Unused or invalid grant encodings are impossible: grant is always one-hot or zero.

Optional Feature:
- Macro: BOOTH_ARB_TIMEOUT_EN.
- Defined: a watchdog counter clears on entering START and increments each cycle spent in START or WAIT.
  - On reaching TIMEOUT_CYCLES: err[g] pulses for one cycle, mul_start = 0, result is unchanged, no done pulse.
  - The rr pointer advances as on a normal completion; state returns to IDLE.
- Not defined: no counter logic is built, err is tied to 0, and the controller waits indefinitely on mul_busy.

Decomposition:
- Package booth_arb_pkg contains:
  - state enum (IDLE, START, WAIT, DONE);
  - default WIDTH/NREQ constants;
  - a helper function extracting slice i from the packed operand buses.
- One sub-module, rr_arbiter: purely the round-robin pick.
  - Inputs: req, pointer. Output: one-hot grant.
  - Instantiated once in booth_mul_arbiter; the FSM and datapath stay in the top module.

Test Plan:
- Single request: req[0] with a=3, b=17 → mul_start ≥1 cycle; done[0] after busy falls; result = 51 (16'h0033).
- Back-to-back from one requester: req[1] with 7×7 held high → result 49, done[1].
  - Next grant only in the cycle after DONE; mul_start never overlaps busy of the previous operation.
- Signed: req[2] with a=-3 (8'hFD), b=5 → result = 16'hFFF1 (-15).
- Round-robin: req = 4'b1111 held, distinct operands per requester → done order 0,1,2,3,0.
  - Each result matches its own requester's product.
- Reset mid-WAIT: assert reset while busy=1 → all outputs 0 immediately (async), no done.
  - After release, the next request begins from requester 0 priority.
- With BOOTH_ARB_TIMEOUT_EN: tie mul_busy=1 and TIMEOUT_CYCLES=8 → err[g] pulses 8 cycles after START entry; no done.
  - The next requester is granted afterwards.
